// File: rtl/scp_containment_ctrl.sv
// SCP containment game controller: tracks per-colour run lengths on the light
// inputs, escalates/decays an alert level and traps light-toggling cheats.
module scp_containment_ctrl #(
    parameter int LEVELS     = 3,
    parameter int TIMER_W    = 6,
    parameter int T_YELLOW   = 10,
    parameter int T_RED      = 3,
    parameter int T_GREEN    = 20,
    parameter int T_BREACH   = 30,
    parameter int CHEAT_MIN  = 3,
    parameter int CHEAT_N    = 4,
    parameter int CHEAT_HOLD = 8
) (
    input  logic                         clock,
    input  logic                         reset,
    input  logic                         green,
    input  logic                         yellow,
    input  logic                         red,
    output logic [LEVELS-1:0]            alarm,
    output logic [$clog2(LEVELS+1)-1:0]  level,
    output logic [2:0]                   state,
    output logic [TIMER_W-1:0]           timer,
    output logic                         cheat_out
);

    localparam int LW = $clog2(LEVELS + 1);
    localparam int CW = $clog2(CHEAT_N + 1);

    localparam logic [TIMER_W-1:0] TY    = TIMER_W'(T_YELLOW);
    localparam logic [TIMER_W-1:0] TR    = TIMER_W'(T_RED);
    localparam logic [TIMER_W-1:0] TG    = TIMER_W'(T_GREEN);
    localparam logic [TIMER_W-1:0] TB    = TIMER_W'(T_BREACH);
    localparam logic [TIMER_W-1:0] TMIN  = TIMER_W'(CHEAT_MIN);
    localparam logic [TIMER_W-1:0] THOLD = TIMER_W'(CHEAT_HOLD);
    localparam logic [TIMER_W-1:0] TMAX  = {TIMER_W{1'b1}};
    localparam logic [LW-1:0]      LMAX  = LW'(LEVELS);
    localparam logic [CW-1:0]      CN    = CW'(CHEAT_N);

    typedef enum logic [1:0] {DARK, GREEN, YELLOW, RED} colour_t;
    typedef enum logic [2:0] {CALM = 3'd0, ALERT = 3'd1, BREACH = 3'd2, CHEAT = 3'd3} state_t;

    state_t               state_q, state_n;
    colour_t              prev_q, prev_n, colour;
    logic [LW-1:0]        level_q, level_n;
    logic [TIMER_W-1:0]   timer_q, timer_n, tn;
    logic [CW-1:0]        cnt_q, cnt_n;
    logic [LEVELS-1:0]    alarm_q, alarm_n;
    logic                 cheat_q, cheat_n;
    logic                 esc, dec;

    function automatic state_t lvl_state(input logic [LW-1:0] l);
        if (l == '0)
            return CALM;
        else if (l == LMAX)
            return BREACH;
        else
            return ALERT;
    endfunction

    always_comb begin
        colour  = DARK;
        state_n = state_q;
        prev_n  = prev_q;
        level_n = level_q;
        timer_n = timer_q;
        cnt_n   = cnt_q;
        tn      = '0;
        esc     = 1'b0;
        dec     = 1'b0;

        if (red)
            colour = RED;
        else if (yellow)
            colour = YELLOW;
        else if (green)
            colour = GREEN;

        if (state_q == CHEAT) begin
            // Inputs are ignored; the hold ends on the edge the count would hit 0.
            if (timer_q <= TIMER_W'(1)) begin
                timer_n = '0;
                prev_n  = DARK;
                cnt_n   = '0;
                state_n = lvl_state(level_q);
            end else begin
                timer_n = timer_q - TIMER_W'(1);
            end
        end else begin
            if (colour != prev_q) begin
                tn = (colour == DARK) ? '0 : TIMER_W'(1);
                if (prev_q != DARK && timer_q < TMIN)
                    cnt_n = cnt_q + CW'(1);
                else
                    cnt_n = '0;
            end else if (colour == DARK) begin
                tn = '0;
            end else begin
                tn = (timer_q == TMAX) ? timer_q : timer_q + TIMER_W'(1);
            end

            esc = (colour == YELLOW && tn == TY) || (colour == RED && tn == TR);
            dec = (colour == GREEN) && (level_q != '0) &&
                  (level_q == LMAX ? (tn == TB) : (tn == TG));

            timer_n = tn;
            if (esc) begin
                level_n = (level_q == LMAX) ? level_q : level_q + LW'(1);
                timer_n = '0;
                cnt_n   = '0;
            end else if (dec) begin
                level_n = level_q - LW'(1);
                timer_n = '0;
                cnt_n   = '0;
            end

            prev_n  = colour;
            state_n = lvl_state(level_n);
            if (cnt_n == CN) begin
                state_n = CHEAT;
                timer_n = THOLD;
            end
        end

        cheat_n = (state_n == CHEAT);
    end

    for (genvar i = 0; i < LEVELS; i++) begin : g_alarm
        assign alarm_n[i] = (level_n > LW'(i));
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= CALM;
            prev_q  <= DARK;
            level_q <= '0;
            timer_q <= '0;
            cnt_q   <= '0;
            alarm_q <= '0;
            cheat_q <= 1'b0;
        end else begin
            state_q <= state_n;
            prev_q  <= prev_n;
            level_q <= level_n;
            timer_q <= timer_n;
            cnt_q   <= cnt_n;
            alarm_q <= alarm_n;
            cheat_q <= cheat_n;
        end
    end

    assign alarm     = alarm_q;
    assign level     = level_q;
    assign state     = state_q;
    assign timer     = timer_q;
    assign cheat_out = cheat_q;

endmodule

// File: tb/tb_scp_containment_ctrl.sv
// Scoreboard bench for scp_containment_ctrl: a behavioural model pushes the
// expected outputs per edge, which are popped and compared after the edge.
module tb_scp_containment_ctrl;

    localparam int LEVELS = 3;

    logic              clock = 1'b0;
    logic              reset = 1'b1;
    logic              green = 1'b0, yellow = 1'b0, red = 1'b0;
    logic [LEVELS-1:0] alarm;
    logic [1:0]        level;
    logic [2:0]        state;
    logic [5:0]        timer;
    logic              cheat_out;

    scp_containment_ctrl dut (
        .clock(clock), .reset(reset), .green(green), .yellow(yellow), .red(red),
        .alarm(alarm), .level(level), .state(state), .timer(timer), .cheat_out(cheat_out)
    );

    always #5 clock = ~clock;

    typedef struct {
        int lvl;
        int st;
        int tmr;
        int ch;
        int al;
    } exp_t;

    exp_t sb[$];
    int n_chk = 0, n_pass = 0;

    // Model state: colour codes 0 dark, 1 green, 2 yellow, 3 red.
    int m_lvl = 0, m_st = 0, m_tmr = 0, m_prev = 0, m_cnt = 0;

    task automatic chk(input string tag, input int obs, input int exp);
        n_chk++;
        if (obs == exp)
            n_pass++;
        else
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    endtask

    function automatic int lvl2st(input int l);
        if (l == 0) return 0;
        if (l == LEVELS) return 2;
        return 1;
    endfunction

    task automatic model_step(input bit rst, input bit g, input bit y, input bit r);
        int c, tn;
        exp_t e;
        if (rst) begin
            m_lvl = 0; m_st = 0; m_tmr = 0; m_prev = 0; m_cnt = 0;
        end else if (m_st == 3) begin
            if (m_tmr == 1) begin
                m_tmr = 0; m_prev = 0; m_cnt = 0; m_st = lvl2st(m_lvl);
            end else begin
                m_tmr--;
            end
        end else begin
            c = r ? 3 : y ? 2 : g ? 1 : 0;
            if (c != m_prev) begin
                if (m_prev != 0 && m_tmr < 3) m_cnt++;
                else m_cnt = 0;
                tn = (c == 0) ? 0 : 1;
            end else begin
                tn = (c == 0) ? 0 : (m_tmr == 63 ? 63 : m_tmr + 1);
            end
            m_tmr = tn;
            if ((c == 2 && tn == 10) || (c == 3 && tn == 3)) begin
                if (m_lvl < LEVELS) m_lvl++;
                m_tmr = 0; m_cnt = 0;
            end else if (c == 1 && ((m_lvl == LEVELS && tn == 30) ||
                                    (m_lvl > 0 && m_lvl < LEVELS && tn == 20))) begin
                m_lvl--;
                m_tmr = 0; m_cnt = 0;
            end
            m_prev = c;
            m_st = lvl2st(m_lvl);
            if (m_cnt == 4) begin
                m_st = 3; m_tmr = 8;
            end
        end
        e.lvl = m_lvl; e.st = m_st; e.tmr = m_tmr;
        e.ch = (m_st == 3) ? 1 : 0;
        e.al = (1 << m_lvl) - 1;
        sb.push_back(e);
    endtask

    task automatic step(input bit rst, input bit g, input bit y, input bit r);
        exp_t e;
        model_step(rst, g, y, r);
        reset = rst; green = g; yellow = y; red = r;
        @(posedge clock);
        #1;
        if (sb.size() == 0) begin
            chk("sb_empty", 0, 1);
        end else begin
            e = sb.pop_front();
            chk("sb_level", int'(level), e.lvl);
            chk("sb_state", int'(state), e.st);
            chk("sb_timer", int'(timer), e.tmr);
            chk("sb_cheat", int'(cheat_out), e.ch);
            chk("sb_alarm", int'(alarm), e.al);
        end
    endtask

    function automatic bit alt_y(input int i);
        return ((i / 2) % 2) == 1;
    endfunction

    task automatic alt_run(input int n);
        for (int i = 0; i < n; i++)
            step(0, !alt_y(i), alt_y(i), 0);
    endtask

    initial begin
        // 1: reset state, then long green in CALM
        step(1, 0, 0, 0);
        chk("rst_level", int'(level), 0);
        chk("rst_timer", int'(timer), 0);
        chk("rst_alarm", int'(alarm), 0);
        for (int i = 0; i < 35; i++) step(0, 1, 0, 0);
        chk("t1_level", int'(level), 0);
        chk("t1_state", int'(state), 0);
        chk("t1_timer", int'(timer), 35);

        // 2: yellow escalation
        for (int i = 1; i <= 21; i++) begin
            step(0, 0, 1, 0);
            if (i == 10) begin
                chk("t2_lvl1", int'(level), 1);
                chk("t2_alarm1", int'(alarm), 1);
                chk("t2_state1", int'(state), 1);
                chk("t2_timer0", int'(timer), 0);
            end
            if (i == 20) begin
                chk("t2_lvl2", int'(level), 2);
                chk("t2_alarm2", int'(alarm), 3);
            end
            if (i == 21) chk("t2_timer1", int'(timer), 1);
        end

        // 3: red escalation into saturated BREACH
        step(1, 0, 0, 0);
        for (int i = 1; i <= 15; i++) begin
            step(0, 0, 0, 1);
            if (i % 3 == 0) chk("t3_timer0", int'(timer), 0);
            if (i <= 9 && i % 3 == 0) chk("t3_level", int'(level), i / 3);
        end
        chk("t3_sat_level", int'(level), 3);
        chk("t3_state", int'(state), 2);
        chk("t3_alarm", int'(alarm), 7);

        // 4: de-escalation on green
        for (int i = 0; i < 30; i++) step(0, 1, 0, 0);
        chk("t4_lvl2", int'(level), 2);
        chk("t4_st1", int'(state), 1);
        chk("t4_al2", int'(alarm), 3);
        for (int i = 0; i < 20; i++) step(0, 1, 0, 0);
        chk("t4_lvl1", int'(level), 1);
        for (int i = 0; i < 20; i++) step(0, 1, 0, 0);
        chk("t4_lvl0", int'(level), 0);
        chk("t4_st0", int'(state), 0);

        // 5: toggling cheat and its hold period
        step(1, 0, 0, 0);
        alt_run(8);
        chk("t5_no_cheat_yet", int'(cheat_out), 0);
        step(0, 1, 0, 0);
        chk("t5_state", int'(state), 3);
        chk("t5_cheat", int'(cheat_out), 1);
        chk("t5_timer", int'(timer), 8);
        for (int k = 1; k <= 8; k++) begin
            step(0, 1'($urandom_range(1)), 1'($urandom_range(1)), 1'($urandom_range(1)));
            chk("t5_hold_timer", int'(timer), 8 - k);
            chk("t5_hold_cheat", int'(cheat_out), k < 8 ? 1 : 0);
        end
        chk("t5_exit_state", int'(state), 0);
        chk("t5_exit_level", int'(level), 0);

        // 6: reset mid-CHEAT, then a fresh 4 short runs are needed
        step(1, 0, 0, 0);
        alt_run(9);
        for (int k = 0; k < 4; k++) step(0, 0, 1, 0);
        chk("t6_timer4", int'(timer), 4);
        step(1, 0, 0, 0);
        chk("t6_rst_state", int'(state), 0);
        chk("t6_rst_cheat", int'(cheat_out), 0);
        chk("t6_rst_timer", int'(timer), 0);
        alt_run(8);
        chk("t6_fresh_no_cheat", int'(cheat_out), 0);
        step(0, 1, 0, 0);
        chk("t6_fresh_cheat", int'(cheat_out), 1);

        // Random runs of random colours, with occasional resets
        step(1, 0, 0, 0);
        for (int n = 0; n < 120; n++) begin
            int c, len;
            c = $urandom_range(3);
            len = ($urandom_range(3) == 0) ? $urandom_range(1, 2) : $urandom_range(1, 32);
            for (int j = 0; j < len; j++)
                step($urandom_range(199) == 0, c == 1, c == 2 || ($urandom_range(3) == 0 && c == 1),
                     c == 3);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
